// File: rtl/fadd_share_ctrl_if.sv
// Bundle of the two requester handshakes plus the shared add-unit operand/result bus.
// slave is the controller's view; master is the requesters' and add unit's view.
interface fadd_share_ctrl_if;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_op1;
  logic [31:0] a_op2;
  logic        a_sub;
  logic        a_rvalid;
  logic [31:0] a_result;

  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_op1;
  logic [31:0] b_op2;
  logic        b_sub;
  logic        b_rvalid;
  logic [31:0] b_result;

  logic [31:0] fu_op1;
  logic [31:0] fu_op2;
  logic [31:0] fu_result;

  modport slave (
    input  a_valid, a_op1, a_op2, a_sub,
    output a_ready, a_rvalid, a_result,
    input  b_valid, b_op1, b_op2, b_sub,
    output b_ready, b_rvalid, b_result,
    output fu_op1, fu_op2,
    input  fu_result
  );

  modport master (
    output a_valid, a_op1, a_op2, a_sub,
    input  a_ready, a_rvalid, a_result,
    output b_valid, b_op1, b_op2, b_sub,
    input  b_ready, b_rvalid, b_result,
    input  fu_op1, fu_op2,
    output fu_result
  );
endinterface

// File: rtl/fadd_share_ctrl.sv
// Round-robin sharing of one fixed-latency float adder between requesters A and B.
// A tag pipeline as deep as the adder steers each result back to its issuer.
module fadd_share_ctrl #(
  parameter int LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset,
  fadd_share_ctrl_if.slave   bus,
  output logic               busy
);

  localparam int DATA_W = 32;

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

  ptr_e              ptr_q, ptr_d;
  logic              grant_a, grant_b, grant_any;

  logic [DATA_W-1:0] fu_op1_q, fu_op1_d;
  logic [DATA_W-1:0] fu_op2_q, fu_op2_d;

  // Tag id: 0 = A, 1 = B. Stage LATENCY lines up with fu_result.
  logic [LATENCY:0]  tag_vld_q, tag_vld_d;
  logic [LATENCY:0]  tag_id_q,  tag_id_d;

  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_result_q, a_result_d;
  logic [DATA_W-1:0] b_result_q, b_result_d;

  logic              ret_vld, ret_id;

  function automatic logic [DATA_W-1:0] flip_sign(input logic [DATA_W-1:0] op,
                                                  input logic              sub);
    return {op[DATA_W-1] ^ sub, op[DATA_W-2:0]};
  endfunction

  // Grants are suppressed while reset is held so no handshake completes.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset) begin
      if (bus.a_valid && (!bus.b_valid || ptr_q == PTR_A)) begin
        grant_a = 1'b1;
      end else if (bus.b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign grant_any   = grant_a | grant_b;
  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_a) begin
      ptr_d = PTR_B;
    end else if (grant_b) begin
      ptr_d = PTR_A;
    end
  end

  always_comb begin
    fu_op1_d = fu_op1_q;
    fu_op2_d = fu_op2_q;
    if (grant_a) begin
      fu_op1_d = bus.a_op1;
      fu_op2_d = flip_sign(bus.a_op2, bus.a_sub);
    end else if (grant_b) begin
      fu_op1_d = bus.b_op1;
      fu_op2_d = flip_sign(bus.b_op2, bus.b_sub);
    end
  end

  assign tag_vld_d = {tag_vld_q[LATENCY-1:0], grant_any};
  assign tag_id_d  = {tag_id_q[LATENCY-1:0],  grant_b};

  assign ret_vld = tag_vld_q[LATENCY];
  assign ret_id  = tag_id_q[LATENCY];

  always_comb begin
    a_rvalid_d = ret_vld & ~ret_id;
    b_rvalid_d = ret_vld &  ret_id;
    a_result_d = a_result_q;
    b_result_d = b_result_q;
    if (a_rvalid_d) begin
      a_result_d = bus.fu_result;
    end
    if (b_rvalid_d) begin
      b_result_d = bus.fu_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= PTR_A;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      fu_op1_q   <= '0;
      fu_op2_q   <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_result_q <= '0;
      b_result_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      fu_op1_q   <= fu_op1_d;
      fu_op2_q   <= fu_op2_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_result_q <= a_result_d;
      b_result_q <= b_result_d;
    end
  end

  assign bus.fu_op1   = fu_op1_q;
  assign bus.fu_op2   = fu_op2_q;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_result = a_result_q;
  assign bus.b_result = b_result_q;

  assign busy = (|tag_vld_q) | a_rvalid_q | b_rvalid_q;

endmodule

// File: tb/tb_fadd_share_ctrl.sv
// Bench for fadd_share_ctrl: behavioural fixed-latency adder, directed vectors,
// and a queue-based scoreboard drained by an independent response monitor.
module tb_fadd_share_ctrl;

  localparam int LATENCY = 3;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  fadd_share_ctrl_if bus();

  fadd_share_ctrl #(.LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single <-> double conversions valid for zero and normal values.
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] bits;
    int          e;
    logic [10:0] e11;
    if (s[30:0] == 31'd0) begin
      bits = {s[31], 63'd0};
    end else begin
      e    = int'(s[30:23]) - 127 + 1023;
      e11  = e[10:0];
      bits = {s[31], e11, s[22:0], 29'd0};
    end
    return $bitstoreal(bits);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] bits;
    int          e;
    logic [7:0]  e8;
    bits = $realtobits(r);
    if (bits[62:0] == 63'd0) return {bits[63], 31'd0};
    e  = int'(bits[62:52]) - 1023 + 127;
    e8 = e[7:0];
    return {bits[63], e8, bits[51:29]};
  endfunction

  function automatic logic [31:0] fadd_ref(input logic [31:0] x, input logic [31:0] y);
    return r2s(s2r(x) + s2r(y));
  endfunction

  // Behavioural shared adder: result appears LATENCY edges after its operands.
  logic [31:0] fu_pipe [LATENCY];
  always @(posedge clk) begin
    fu_pipe[0] <= fadd_ref(bus.fu_op1, bus.fu_op2);
    for (int i = 1; i < LATENCY; i++) fu_pipe[i] <= fu_pipe[i-1];
  end
  assign bus.fu_result = fu_pipe[LATENCY-1];

  typedef struct {
    logic        id;
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t ordq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic ret(input logic id, input logic [31:0] res);
    exp_t e;
    if (ordq.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL unexpected_rvalid: got rvalid on %s with result %h, required none",
               id ? "B" : "A", res);
    end else begin
      e = ordq.pop_front();
      check("ret_requester", 32'(id), 32'(e.id));
      check("ret_result", res, e.res);
      check("ret_cycle", cyc, e.due);
    end
  endtask

  always @(negedge clk) begin
    if (bus.a_rvalid) ret(1'b0, bus.a_result);
    if (bus.b_rvalid) ret(1'b1, bus.b_result);
  end

  // One cycle of stimulus: present requests, check grants, log accepted work.
  task automatic drive(input logic av, input logic [31:0] a1, input logic [31:0] a2,
                       input logic as_, input logic [31:0] ares,
                       input logic bv, input logic [31:0] b1, input logic [31:0] b2,
                       input logic bs, input logic [31:0] bres,
                       input logic era, input logic erb, input string tag);
    @(negedge clk);
    bus.a_valid = av; bus.a_op1 = a1; bus.a_op2 = a2; bus.a_sub = as_;
    bus.b_valid = bv; bus.b_op1 = b1; bus.b_op2 = b2; bus.b_sub = bs;
    #1;
    check({tag, " a_ready"}, 32'(bus.a_ready), 32'(era));
    check({tag, " b_ready"}, 32'(bus.b_ready), 32'(erb));
    if (bus.a_ready) ordq.push_back('{1'b0, ares, cyc + LATENCY + 2});
    if (bus.b_ready) ordq.push_back('{1'b1, bres, cyc + LATENCY + 2});
    @(posedge clk);
    #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (ordq.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (ordq.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s drain: %0d responses outstanding, required 0", name, ordq.size());
      ordq.delete();
    end
    @(negedge clk);
    #1;
    check({name, " busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  logic        av, bv, as_, bs, ptr_m;
  logic [31:0] a1, a2, b1, b2;
  real         ra1, ra2, rb1, rb2;

  initial begin
    reset = 1'b0;
    bus.a_valid = 1'b0; bus.a_op1 = '0; bus.a_op2 = '0; bus.a_sub = 1'b0;
    bus.b_valid = 1'b0; bus.b_op1 = '0; bus.b_op2 = '0; bus.b_sub = 1'b0;

    // Reset state, including grants held low against pending requests.
    repeat (2) @(negedge clk);
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    #1;
    check("rst a_ready", 32'(bus.a_ready), 32'd0);
    check("rst b_ready", 32'(bus.b_ready), 32'd0);
    check("rst a_rvalid", 32'(bus.a_rvalid), 32'd0);
    check("rst b_rvalid", 32'(bus.b_rvalid), 32'd0);
    check("rst a_result", bus.a_result, 32'd0);
    check("rst b_result", bus.b_result, 32'd0);
    check("rst fu_op1", bus.fu_op1, 32'd0);
    check("rst fu_op2", bus.fu_op2, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Single add from A: 1.0 + 2.0 = 3.0
    drive(1, 32'h3F800000, 32'h40000000, 0, 32'h40400000,
          0, 32'h0, 32'h0, 0, 32'h0, 1, 0, "add_a");
    @(negedge clk);
    #1;
    check("add_a fu_op1", bus.fu_op1, 32'h3F800000);
    check("add_a busy", 32'(busy), 32'd1);
    drain("add_a");

    // Subtract from B: 3.0 - 1.0 = 2.0, operand 2 goes out negated
    drive(0, 32'h0, 32'h0, 0, 32'h0,
          1, 32'h40400000, 32'h3F800000, 1, 32'h40000000, 0, 1, "sub_b");
    @(negedge clk);
    #1;
    check("sub_b fu_op2", bus.fu_op2, 32'hBF800000);
    drain("sub_b");

    // 0 - 0: the sign of a zero operand is flipped too
    drive(0, 32'h0, 32'h0, 0, 32'h0,
          1, 32'h00000000, 32'h00000000, 1, 32'h00000000, 0, 1, "zero_b");
    @(negedge clk);
    #1;
    check("zero_b fu_op2", bus.fu_op2, 32'h80000000);
    drain("zero_b");

    // Fairness: B alone, an idle cycle, then both -> A wins
    drive(0, 32'h0, 32'h0, 0, 32'h0,
          1, 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 0, 1, "fair_b");
    @(negedge clk);
    drive(1, 32'h40000000, 32'h40000000, 0, 32'h40800000,
          1, 32'h40400000, 32'h3F800000, 0, 32'h40800000, 1, 0, "fair_ab1");
    drive(1, 32'h40000000, 32'h40000000, 0, 32'h40800000,
          1, 32'h40400000, 32'h3F800000, 0, 32'h40800000, 0, 1, "fair_ab2");

    // Contention: both valid four cycles, alternating A,B,A,B
    drive(1, 32'h40800000, 32'h40A00000, 0, 32'h41100000,
          1, 32'h41000000, 32'h40400000, 1, 32'h40A00000, 1, 0, "cont1");
    drive(1, 32'h40800000, 32'h40A00000, 0, 32'h41100000,
          1, 32'h41000000, 32'h40400000, 1, 32'h40A00000, 0, 1, "cont2");
    drive(1, 32'h41200000, 32'h3F800000, 0, 32'h41300000,
          1, 32'h40000000, 32'h40C00000, 1, 32'hC0800000, 1, 0, "cont3");
    drive(1, 32'h41200000, 32'h3F800000, 0, 32'h41300000,
          1, 32'h40000000, 32'h40C00000, 1, 32'hC0800000, 0, 1, "cont4");
    drain("cont");

    // Reset mid-flight: three A operations are discarded, pointer returns to A
    drive(1, 32'h3F800000, 32'h3F800000, 0, 32'h40000000,
          0, 32'h0, 32'h0, 0, 32'h0, 1, 0, "flight1");
    drive(1, 32'h40000000, 32'h40000000, 0, 32'h40800000,
          0, 32'h0, 32'h0, 0, 32'h0, 1, 0, "flight2");
    drive(1, 32'h40400000, 32'h3F800000, 0, 32'h40800000,
          0, 32'h0, 32'h0, 0, 32'h0, 1, 0, "flight3");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ordq.delete();
    #1;
    check("midrst a_rvalid", 32'(bus.a_rvalid), 32'd0);
    check("midrst b_rvalid", 32'(bus.b_rvalid), 32'd0);
    check("midrst a_result", bus.a_result, 32'd0);
    check("midrst b_result", bus.b_result, 32'd0);
    check("midrst fu_op1", bus.fu_op1, 32'd0);
    check("midrst fu_op2", bus.fu_op2, 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1, 32'h3F800000, 32'h40000000, 0, 32'h40400000,
          1, 32'h40400000, 32'h3F800000, 1, 32'h40000000, 1, 0, "post_rst");
    drain("post_rst");

    // Random stream from a fresh reset so the pointer model starts at A
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ptr_m = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      av  = ($urandom_range(0, 3) != 0);
      bv  = ($urandom_range(0, 3) != 0);
      as_ = $urandom_range(0, 1) != 0;
      bs  = $urandom_range(0, 1) != 0;
      ra1 = real'(int'($urandom_range(0, 2000)) - 1000);
      ra2 = real'(int'($urandom_range(0, 2000)) - 1000);
      rb1 = real'(int'($urandom_range(0, 2000)) - 1000);
      rb2 = real'(int'($urandom_range(0, 2000)) - 1000);
      a1 = r2s(ra1); a2 = r2s(ra2);
      b1 = r2s(rb1); b2 = r2s(rb2);
      drive(av, a1, a2, as_, r2s(as_ ? ra1 - ra2 : ra1 + ra2),
            bv, b1, b2, bs,  r2s(bs  ? rb1 - rb2 : rb1 + rb2),
            av && (!bv || !ptr_m), bv && !(av && (!bv || !ptr_m)), "rnd");
      if (av && (!bv || !ptr_m)) ptr_m = 1'b1;
      else if (bv) ptr_m = 1'b0;
    end
    drain("rnd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
